// File: rtl/seg7_scan_ctrl.sv
// Eight-digit seven-segment scan controller with frame-synchronous double-buffered display data.
// Define SEG7_SCAN_BLANK_EN to add BLANK_CYCLES of all-off anti-ghosting time after every digit slot.
module seg7_scan_ctrl #(
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_i,
   input  logic [7:0]  dp_i,
   input  logic [7:0]  digit_en_i,
   input  logic        load_i,
   output logic        load_ack_o,
   output logic [2:0]  an_gen_o,
   output logic        an_blank_o,
   output logic [6:0]  seg_o,
   output logic        dp_o,
   output logic        frame_o
);
   localparam int             PS_W    = $clog2(PRESCALE);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   if (PRESCALE < 2 || BLANK_CYCLES < 1) begin : gParamCheck
      $error("seg7_scan_ctrl: PRESCALE must be >= 2 and BLANK_CYCLES >= 1");
   end

   typedef enum logic {SHOW, BLANK} state_t;

   state_t            state_q, state_d;
   logic [PS_W-1:0]   prescale_q, prescale_d;
   logic [2:0]        index_q, index_d;
   logic [31:0]       stageData_q, stageData_d;
   logic [7:0]        stageDp_q, stageDp_d;
   logic [7:0]        stageEn_q, stageEn_d;
   logic [31:0]       shadowData_q, shadowData_d;
   logic [7:0]        shadowDp_q, shadowDp_d;
   logic [7:0]        shadowEn_q, shadowEn_d;
   logic              pending_q, pending_d;
   logic              anBlank_q, anBlank_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;
   logic              loadAck_q, loadAck_d;
   logic              frame_q, frame_d;
   logic              advance, wrap, commit, lit;

`ifdef SEG7_SCAN_BLANK_EN
   localparam int              BL_W    = $clog2(BLANK_CYCLES + 1);
   localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLANK_CYCLES - 1);
   logic [BL_W-1:0] blankCnt_q, blankCnt_d;
`endif

   function automatic logic [6:0] hexFont(input logic [3:0] nibble);
      case (nibble)
         4'h0:    hexFont = 7'h40;
         4'h1:    hexFont = 7'h79;
         4'h2:    hexFont = 7'h24;
         4'h3:    hexFont = 7'h30;
         4'h4:    hexFont = 7'h19;
         4'h5:    hexFont = 7'h12;
         4'h6:    hexFont = 7'h02;
         4'h7:    hexFont = 7'h78;
         4'h8:    hexFont = 7'h00;
         4'h9:    hexFont = 7'h10;
         4'hA:    hexFont = 7'h08;
         4'hB:    hexFont = 7'h03;
         4'hC:    hexFont = 7'h46;
         4'hD:    hexFont = 7'h21;
         4'hE:    hexFont = 7'h06;
         default: hexFont = 7'h0E;
      endcase
   endfunction

   always_comb begin
      state_d      = state_q;
      prescale_d   = prescale_q;
      advance      = 1'b0;
`ifdef SEG7_SCAN_BLANK_EN
      blankCnt_d   = blankCnt_q;
`endif
      case (state_q)
         SHOW: begin
            if (prescale_q == PS_LAST) begin
               prescale_d = '0;
`ifdef SEG7_SCAN_BLANK_EN
               state_d    = BLANK;
`else
               advance    = 1'b1;
`endif
            end else begin
               prescale_d = prescale_q + 1'b1;
            end
         end
         default: begin
`ifdef SEG7_SCAN_BLANK_EN
            if (blankCnt_q == BL_LAST) begin
               blankCnt_d = '0;
               state_d    = SHOW;
               advance    = 1'b1;
            end else begin
               blankCnt_d = blankCnt_q + 1'b1;
            end
`else
            state_d = SHOW;
`endif
         end
      endcase

      index_d = advance ? index_q + 3'd1 : index_q;
      wrap    = advance && (index_q == 3'd7);
      commit  = wrap && pending_q;

      // Staging always takes a new load; shadow only changes at the frame wrap, taking the old staging.
      stageData_d  = load_i ? data_i     : stageData_q;
      stageDp_d    = load_i ? dp_i       : stageDp_q;
      stageEn_d    = load_i ? digit_en_i : stageEn_q;
      pending_d    = load_i ? 1'b1 : (commit ? 1'b0 : pending_q);
      shadowData_d = commit ? stageData_q : shadowData_q;
      shadowDp_d   = commit ? stageDp_q   : shadowDp_q;
      shadowEn_d   = commit ? stageEn_q   : shadowEn_q;

      // Outputs are computed from next-state values so they register on the same edge as index/state.
      lit       = (state_d == SHOW) && shadowEn_d[index_d];
      anBlank_d = ~lit;
      seg_d     = lit ? hexFont(shadowData_d[{index_d, 2'b00} +: 4]) : 7'h7F;
      dp_d      = lit ? ~shadowDp_d[index_d] : 1'b1;
      frame_d   = wrap;
      loadAck_d = commit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= SHOW;
         prescale_q   <= '0;
         index_q      <= '0;
         stageData_q  <= '0;
         stageDp_q    <= '0;
         stageEn_q    <= '0;
         shadowData_q <= '0;
         shadowDp_q   <= '0;
         shadowEn_q   <= '0;
         pending_q    <= 1'b0;
         anBlank_q    <= 1'b1;
         seg_q        <= 7'h7F;
         dp_q         <= 1'b1;
         loadAck_q    <= 1'b0;
         frame_q      <= 1'b0;
`ifdef SEG7_SCAN_BLANK_EN
         blankCnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         prescale_q   <= prescale_d;
         index_q      <= index_d;
         stageData_q  <= stageData_d;
         stageDp_q    <= stageDp_d;
         stageEn_q    <= stageEn_d;
         shadowData_q <= shadowData_d;
         shadowDp_q   <= shadowDp_d;
         shadowEn_q   <= shadowEn_d;
         pending_q    <= pending_d;
         anBlank_q    <= anBlank_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         loadAck_q    <= loadAck_d;
         frame_q      <= frame_d;
`ifdef SEG7_SCAN_BLANK_EN
         blankCnt_q   <= blankCnt_d;
`endif
      end
   end

   assign an_gen_o   = index_q;
   assign an_blank_o = anBlank_q;
   assign seg_o      = seg_q;
   assign dp_o       = dp_q;
   assign load_ack_o = loadAck_q;
   assign frame_o    = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with PRESCALE=4, BLANK_CYCLES=2.
// Works with SEG7_SCAN_BLANK_EN either defined or undefined.
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;
   localparam int PS = 4;
   localparam int BC = 2;
`ifdef SEG7_SCAN_BLANK_EN
   localparam int SLOT = PS + BC;
`else
   localparam int SLOT = PS;
`endif
   localparam int FRAME = 8 * SLOT;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_i;
   logic [7:0]  dp_i;
   logic [7:0]  digit_en_i;
   logic        load_i;
   logic        load_ack_o;
   logic [2:0]  an_gen_o;
   logic        an_blank_o;
   logic [6:0]  seg_o;
   logic        dp_o;
   logic        frame_o;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.PRESCALE(PS), .BLANK_CYCLES(BC)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_i     (data_i),
      .dp_i       (dp_i),
      .digit_en_i (digit_en_i),
      .load_i     (load_i),
      .load_ack_o (load_ack_o),
      .an_gen_o   (an_gen_o),
      .an_blank_o (an_blank_o),
      .seg_o      (seg_o),
      .dp_o       (dp_o),
      .frame_o    (frame_o)
   );

   int          totalChecks;
   int          passedChecks;
   int          k;
   int          wrapK;
   logic [31:0] dispData;
   logic [7:0]  dispDp;
   logic [7:0]  dispEn;
   logic [6:0]  font [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
      totalChecks++;
      if (actual === expected) passedChecks++;
      else $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, actual, expected);
   endtask

   task automatic applyStimulus(input logic load, input logic [31:0] d, input logic [7:0] dp,
                                input logic [7:0] en);
      load_i     = load;
      data_i     = d;
      dp_i       = dp;
      digit_en_i = en;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   // Expected {an_gen, an_blank, seg, dp, frame, ack} for cycle cyc of the scan, given the displayed data.
   function automatic logic [15:0] expectedVec(input int cyc, input logic ackExp);
      int         idx;
      int         pos;
      logic       on;
      logic [3:0] nib;
      idx = (cyc / SLOT) % 8;
      pos = cyc % SLOT;
      on  = (pos < PS) && dispEn[idx];
      nib = dispData[idx*4 +: 4];
      return {2'b00, 3'(idx), ~on, (on ? font[nib] : 7'h7F), (on ? ~dispDp[idx] : 1'b1),
              ((cyc != 0) && (cyc % FRAME == 0)), ackExp};
   endfunction

   task automatic checkCycle(input string tag, input logic ackExp);
      checkOutput($sformatf("%s@%0d", tag, k),
                  {2'b00, an_gen_o, an_blank_o, seg_o, dp_o, frame_o, load_ack_o},
                  expectedVec(k, ackExp));
   endtask

   task automatic runUntil(input string tag, input int target);
      while (k < target) begin
         tick();
         checkCycle(tag, 1'b0);
      end
   endtask

   initial begin
      totalChecks  = 0;
      passedChecks = 0;
      k            = 0;
      rst          = 1'b1;
      applyStimulus(1'b0, 32'h0, 8'h0, 8'h0);
      dispData = '0;
      dispDp   = '0;
      dispEn   = '0;

      // Reset, then free-run with nothing loaded: display stays dark while the index scans.
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      k   = 0;
      checkCycle("reset", 1'b0);
      runUntil("idle", 100);

      // First load commits at the next wrap, ack coinciding with frame.
      applyStimulus(1'b1, 32'h76543210, 8'h81, 8'hFF);
      tick();
      checkCycle("load1", 1'b0);
      applyStimulus(1'b0, 32'h0, 8'h0, 8'h0);
      wrapK = (k / FRAME + 1) * FRAME;
      runUntil("wait1", wrapK - 1);
      dispData = 32'h76543210;
      dispDp   = 8'h81;
      dispEn   = 8'hFF;
      tick();
      checkCycle("commit1", 1'b1);
      checkOutput("d0seg", {9'd0, seg_o}, 16'h0040);
      runUntil("frame1", wrapK + SLOT);
      checkOutput("d1seg", {6'd0, an_gen_o, seg_o}, {6'd0, 3'd1, 7'h79});
      runUntil("frame1", wrapK + 7 * SLOT);
      checkOutput("d7seg", {6'd0, an_gen_o, seg_o}, {6'd0, 3'd7, 7'h78});

      // Two loads before one wrap: last one wins, single ack.
      runUntil("frame1", wrapK + FRAME + 5);
      applyStimulus(1'b1, 32'hAAAAAAAA, 8'hFF, 8'hFF);
      tick();
      checkCycle("loadA", 1'b0);
      applyStimulus(1'b1, 32'hBBBBBBBB, 8'h00, 8'hFF);
      tick();
      checkCycle("loadB", 1'b0);
      applyStimulus(1'b0, 32'h0, 8'h0, 8'h0);
      wrapK = wrapK + 2 * FRAME;
      runUntil("wait2", wrapK - 1);
      dispData = 32'hBBBBBBBB;
      dispDp   = 8'h00;
      dispEn   = 8'hFF;
      tick();
      checkCycle("commit2", 1'b1);
      checkOutput("bSeg", {9'd0, seg_o}, 16'h0003);

      // Stage X mid-frame, then load Y exactly on the wrap edge: X commits now, Y one frame later.
      runUntil("frame2", wrapK + 5);
      applyStimulus(1'b1, 32'h01234567, 8'h0F, 8'h5A);
      tick();
      checkCycle("loadX", 1'b0);
      applyStimulus(1'b0, 32'h0, 8'h0, 8'h0);
      runUntil("frame2", wrapK + FRAME - 1);
      applyStimulus(1'b1, 32'hFEDCBA98, 8'hF0, 8'hFF);
      dispData = 32'h01234567;
      dispDp   = 8'h0F;
      dispEn   = 8'h5A;
      tick();
      checkCycle("commitX", 1'b1);
      applyStimulus(1'b0, 32'h0, 8'h0, 8'h0);
      wrapK = wrapK + FRAME;
      runUntil("frameX", wrapK + FRAME - 1);
      dispData = 32'hFEDCBA98;
      dispDp   = 8'hF0;
      dispEn   = 8'hFF;
      tick();
      checkCycle("commitY", 1'b1);
      wrapK = wrapK + FRAME;

      // Pending load discarded by a reset issued while digit 5 is scanning.
      runUntil("frameY", wrapK + 2);
      applyStimulus(1'b1, 32'h0F0F0F0F, 8'hFF, 8'hFF);
      tick();
      checkCycle("loadZ", 1'b0);
      applyStimulus(1'b0, 32'h0, 8'h0, 8'h0);
      runUntil("frameY", wrapK + 5 * SLOT + 1);
      checkOutput("idx5", {13'd0, an_gen_o}, 16'd5);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      k        = 0;
      dispData = '0;
      dispDp   = '0;
      dispEn   = '0;
      checkCycle("midReset", 1'b0);
      runUntil("postReset", FRAME + 2);

      $display("%0d/%0d checks passed", passedChecks, totalChecks);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment display. Cycles a 3-bit digit index through 0..7 at a programmable rate, drives the anode generator's index and blanking inputs, and decodes the selected hex nibble to active-low cathodes. New display data is double-buffered and committed only at frame boundaries, so a displayed frame never mixes old and new data.

## Interface
- PRESCALE, 50000: clock cycles each digit is lit per slot; must be ≥ 2. Counter width is $clog2(PRESCALE).
- BLANK_CYCLES, 500: all-off cycles at the end of each slot, when blanking is compiled in; must be ≥ 1.

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- data_i  in  32  eight hex nibbles; nibble k = data_i[4k+3:4k] is shown on digit k
- dp_i  in  8  decimal point per digit, 1 = lit
- digit_en_i  in  8  per-digit enable, 0 = digit dark for its slot
- load_i  in  1  one-cycle strobe that stages data_i, dp_i and digit_en_i
- load_ack_o  out  1  one-cycle pulse when staged values become the displayed values
- an_gen_o  out  3  current digit index, drives the anode generator index input
- an_blank_o  out  1  1 = all anodes off, drives the anode generator's blanking/reset input
- seg_o  out  7  cathodes {g,f,e,d,c,b,a}, active low
- dp_o  out  1  decimal point cathode, active low
- frame_o  out  1  one-cycle pulse on the first cycle of digit 0

## Operation
- Registers:
  - staging: data, dp, enable
  - shadow: displayed copy of data, dp, enable
  - pending flag
  - prescaler
  - digit index
  - FSM state: SHOW or BLANK
- Reset values:
  - index 0, prescaler 0, state SHOW
  - staging and shadow all 0, pending 0
  - an_gen_o 0, an_blank_o 1, seg_o 7'h7F, dp_o 1, load_ack_o 0, frame_o 0
  - Because shadow enable resets to 0, the display stays dark until the first commit.
- SHOW state:
  - Prescaler counts 0..PRESCALE-1.
  - an_blank_o is the inverse of shadow_en[index].
  - seg_o is the hex font of shadow nibble[index]; dp_o is the inverse of shadow_dp[index].
  - A disabled digit drives an_blank_o=1, seg_o=7'h7F, dp_o=1 but still uses its full slot, so brightness is uniform.
- Slot end: at prescaler = PRESCALE-1 the FSM either goes to BLANK (blanking compiled in) or advances the index (blanking compiled out).
- BLANK state:
  - Counts BLANK_CYCLES cycles with an_blank_o=1, seg_o=7'h7F, dp_o=1.
  - an_gen_o holds the old index throughout, then the index advances and the FSM returns to SHOW.
- Index advance: index + 1 mod 8; 7 wraps to 0.
- Hex font, values 0..F in order: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E (hex).
- Load:
  - load_i copies all three inputs into staging and sets pending.
  - A repeated load_i before commit overwrites staging (last load wins).
- Commit:
  - Occurs on the edge where the index wraps 7→0 with pending set.
  - Effects: shadow ← staging, pending ← 0, load_ack_o = 1 in the first cycle of digit 0.
  - Digit 0 shows the new data from that same cycle.
- Simultaneous load_i and wrap edge: the existing staging content is committed. The new load_i overwrites staging and leaves pending set, so its values commit at the next wrap.
- Reset mid-frame or mid-blank: everything returns to reset values on the next edge. Any pending load is discarded.

## Timing
- All outputs are registered. an_gen_o, an_blank_o, seg_o and dp_o change on the same edge as the index/state registers, with no extra pipeline stage.
- Slot length:
  - PRESCALE cycles with blanking compiled out.
  - PRESCALE + BLANK_CYCLES cycles with blanking compiled in.
- Frame length is 8 × slot length. frame_o has the same period.
- Load-to-display latency: from 1 cycle (load on the last cycle before a wrap) up to 8 slots + 1 cycle.
- load_ack_o and frame_o coincide whenever a commit happens.

## Configuration
- SEG7_SCAN_BLANK_EN defined: the BLANK state is compiled in, giving inter-digit anti-ghosting blanking of BLANK_CYCLES per slot.
- SEG7_SCAN_BLANK_EN undefined: the BLANK state and its counter are removed. The index advances directly at prescaler terminal count, and BLANK_CYCLES is ignored.

## Test plan
Bench uses PRESCALE=4, BLANK_CYCLES=2.
- Reset then run 100 cycles with no load -> an_blank_o stays 1 and seg_o stays 7'h7F; an_gen_o steps 0..7 with frame_o every 32 cycles (blanking out) or 48 cycles (blanking in).
- load_i with data_i=32'h76543210, digit_en_i=8'hFF -> at the next wrap load_ack_o and frame_o pulse together. Digit 0 shows seg_o=7'h40, digit 1 shows 7'h79, digit 7 shows 7'h78.
- Blanking compiled in -> each slot is 4 cycles lit then 2 cycles with an_blank_o=1 and seg_o=7'h7F, with an_gen_o unchanged during the blank.
- Two loads (32'hAAAAAAAA, then 32'hBBBBBBBB) before a wrap -> a single ack; every digit shows seg_o=7'h03.
- load_i asserted on the wrap edge -> the previously staged value commits. The new value commits one frame later with a second ack.
- rst asserted while an_gen_o=5 -> the next cycle shows an_gen_o=0, an_blank_o=1, pending cleared, and no ack at the following wrap.
